// File: rtl/iq_pkg.sv
// ----------------------------------------------------------------------------
// iq_pkg
// Shared types and defaults for the instruction prefetch queue.
//   iq_entry_t            : one queued byte tagged with its fetch address
//   DATA_W_DEFAULT        : default byte width of queue entries and the IR
//   ADDR_W_DEFAULT        : default width of the fetch-address tag
//   RESET_OPCODE_DEFAULT  : IR contents after reset (NOP opcode)
// ----------------------------------------------------------------------------
package iq_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int ADDR_W_DEFAULT = 16;

    localparam logic [DATA_W_DEFAULT-1:0] RESET_OPCODE_DEFAULT = 8'hEA;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] data;
        logic [ADDR_W_DEFAULT-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/instruction_queue_if.sv
// ----------------------------------------------------------------------------
// instruction_queue_if
// Groups the fetch-side and decoder-side signals of the instruction queue.
//   master : fetch unit / decoder side (drives requests, observes status)
//   slave  : the queue itself
// Fetch side  : fetch_valid, fetch_ready, data_in, fetch_pc
// Control     : flush
// Decoder side: ir_load, ir_out, ir_pc, ir_valid, opnd_pop, opnd_out,
//               opnd_valid, count
// ----------------------------------------------------------------------------
interface instruction_queue_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              fetch_valid;
    logic              fetch_ready;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] fetch_pc;
    logic              flush;
    logic              ir_load;
    logic [DATA_W-1:0] ir_out;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              opnd_pop;
    logic [DATA_W-1:0] opnd_out;
    logic              opnd_valid;
    logic [CNT_W-1:0]  count;

    modport master (
        output fetch_valid, data_in, fetch_pc, flush, ir_load, opnd_pop,
        input  fetch_ready, ir_out, ir_pc, ir_valid, opnd_out, opnd_valid, count
    );

    modport slave (
        input  fetch_valid, data_in, fetch_pc, flush, ir_load, opnd_pop,
        output fetch_ready, ir_out, ir_pc, ir_valid, opnd_out, opnd_valid, count
    );

endinterface

// File: rtl/iq_ring.sv
// ----------------------------------------------------------------------------
// iq_ring
// Circular storage for the prefetch queue: storage array, read/write
// pointers and an explicit occupancy counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : request to write wrData_i (ignored when full or flushing)
//   pop_i         : request to drop the head entry (ignored when empty or flushing)
//   flush_i       : discard everything (highest priority)
//   wrData_i      : {data, pc} to write
//   headData_o    : {data, pc} at the read pointer
//   full_o/empty_o: occupancy status from registered count
//   count_o       : occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module iq_ring #(
    parameter int ENTRY_W = 24,
    parameter int DEPTH   = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] wrData_i,
    output logic [ENTRY_W-1:0] headData_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               doPush;
    logic               doPop;

    // Status comes only from the registered count, so a pop in the same
    // cycle never frees a slot for a push while full.
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign headData_o = mem_q[rdPtr_q];

    assign doPush = push_i && !full_o && !flush_i;
    assign doPop  = pop_i && !empty_o && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; stale contents are never
    // visible because count gates every read.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

endmodule

// File: rtl/instruction_queue.sv
// ----------------------------------------------------------------------------
// instruction_queue
// Prefetch queue feeding a registered instruction register (IR) and an
// operand head port for the decoder.
//   fclk : clock (rising edge)
//   resb : asynchronous active-low reset
//   bus  : instruction_queue_if slave modport
//          fetch_valid/fetch_ready/data_in/fetch_pc : push side
//          flush                                    : discard queue, kill IR
//          ir_load -> ir_out/ir_pc/ir_valid          : opcode load into IR
//          opnd_pop -> opnd_out/opnd_valid           : operand consumption
//          count                                    : occupancy
// ----------------------------------------------------------------------------
module instruction_queue
    import iq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter logic [DATA_W-1:0] RESET_OPCODE = DATA_W'(RESET_OPCODE_DEFAULT)
) (
    input  logic                fclk,
    input  logic                resb,
    instruction_queue_if.slave  bus
);

    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic [ENTRY_W-1:0] headData;
    logic [DATA_W-1:0]  headByte;
    logic [ADDR_W-1:0]  headPc;
    logic               ringFull;
    logic               ringEmpty;
    logic               popReq;

    logic [DATA_W-1:0]  irOut_q, irOut_d;
    logic [ADDR_W-1:0]  irPc_q, irPc_d;
    logic               irValid_q, irValid_d;

    // Either decoder request consumes exactly one entry; the ring ignores it
    // when empty or when a flush is in progress.
    assign popReq = bus.ir_load || bus.opnd_pop;

    iq_ring #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_ring (
        .clk_i      (fclk),
        .rst_ni     (resb),
        .push_i     (bus.fetch_valid),
        .pop_i      (popReq),
        .flush_i    (bus.flush),
        .wrData_i   ({bus.data_in, bus.fetch_pc}),
        .headData_o (headData),
        .full_o     (ringFull),
        .empty_o    (ringEmpty),
        .count_o    (bus.count)
    );

    assign headByte = headData[ENTRY_W-1:ADDR_W];
    assign headPc   = headData[ADDR_W-1:0];

    assign bus.fetch_ready = !ringFull;
    assign bus.opnd_valid  = !ringEmpty;
    assign bus.opnd_out    = headByte;
    assign bus.ir_out      = irOut_q;
    assign bus.ir_pc       = irPc_q;
    assign bus.ir_valid    = irValid_q;

    // IR next state: flush only kills validity, an ir_load on an empty queue
    // produces a bubble that keeps the old opcode but marks it dead.
    always_comb begin
        irOut_d   = irOut_q;
        irPc_d    = irPc_q;
        irValid_d = irValid_q;
        if (bus.flush) begin
            irValid_d = 1'b0;
        end else if (bus.ir_load) begin
            if (!ringEmpty) begin
                irOut_d   = headByte;
                irPc_d    = headPc;
                irValid_d = 1'b1;
            end else begin
                irValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            irOut_q   <= RESET_OPCODE;
            irPc_q    <= '0;
            irValid_q <= 1'b0;
        end else begin
            irOut_q   <= irOut_d;
            irPc_q    <= irPc_d;
            irValid_q <= irValid_d;
        end
    end

endmodule
